// File: rtl/snd_pkg.sv
// Shared sound-path types: global enable, tone channel states, index-width helper.
// Latency: n/a (types only); backpressure: n/a.
package snd_pkg;

   typedef enum logic {
      OFF = 1'b0,
      ON  = 1'b1
   } MODE_TYPES;

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } TONE_STATE;

   // Selector index width; a single channel still gets a 1-bit index.
   function automatic int idx_w(input int ch);
      return (ch > 1) ? $clog2(ch) : 1;
   endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave tone channel: half-period counter, tick counter, phase; first tick P+2 cycles after start.
// Latency: busy one cycle after start; backpressure: none, start/abort accepted every cycle.
module tone_channel
   import snd_pkg::*;
#(
   parameter int N     = 8,
   parameter int DUR_W = 8
) (
   input  logic             clk,
   input  logic             nRst,
   input  MODE_TYPES        mode,
   input  logic             start,
   input  logic [N-1:0]     period,
   input  logic [DUR_W-1:0] dur,
   output logic             busy,
   output logic             done,
   output logic             tick,
   output logic             phase
);

   TONE_STATE        state_q, state_d;
   logic [N-1:0]     count_q, count_d, per_q, per_d;
   logic [DUR_W-1:0] tcnt_q, tcnt_d, dur_q, dur_d;
   logic             phase_q, phase_d, tick_q, tick_d, done_q, done_d;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= IDLE;
         count_q <= '0;
         per_q   <= '0;
         tcnt_q  <= '0;
         dur_q   <= '0;
         phase_q <= 1'b0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         per_q   <= per_d;
         tcnt_q  <= tcnt_d;
         dur_q   <= dur_d;
         phase_q <= phase_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      per_d   = per_q;
      tcnt_d  = tcnt_q;
      dur_d   = dur_q;
      phase_d = phase_q;
      tick_d  = 1'b0;
      done_d  = 1'b0;
      if (mode == OFF) begin
         state_d = IDLE;
         count_d = '0;
         tcnt_d  = '0;
         phase_d = 1'b0;
      end else if (start) begin
         // A start always aborts the current note; zero duration just leaves the channel idle.
         count_d = '0;
         tcnt_d  = '0;
         phase_d = 1'b0;
         if (dur != '0) begin
            state_d = PLAY;
            per_d   = period;
            dur_d   = dur;
         end else begin
            state_d = IDLE;
         end
      end else begin
         case (state_q)
            IDLE: begin
               count_d = '0;
               tcnt_d  = '0;
               phase_d = 1'b0;
            end
            PLAY: begin
               if (count_q >= per_q) begin
                  count_d = '0;
                  tick_d  = 1'b1;
                  phase_d = ~phase_q;
                  if (tcnt_q == dur_q - DUR_W'(1)) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                     tcnt_d  = '0;
                  end else begin
                     tcnt_d = tcnt_q + DUR_W'(1);
                  end
               end else begin
                  count_d = count_q + N'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign busy  = (state_q == PLAY);
   assign done  = done_q;
   assign tick  = tick_q;
   assign phase = phase_q;

endmodule

// File: rtl/tone_gen.sv
// Multi-channel tone generator; lowest-index busy (or final-ticking) channel drives tick/wave.
// Latency: selection is combinational on registered channel state; backpressure: none.
module tone_gen
   import snd_pkg::*;
#(
   parameter int N        = 8,
   parameter int DUR_W    = 8,
   parameter int CHANNELS = 2
) (
   input  logic                               clk,
   input  logic                               nRst,
   input  MODE_TYPES                          state,
   input  logic [CHANNELS-1:0]                start,
   input  logic [CHANNELS-1:0][N-1:0]         period,
   input  logic [CHANNELS-1:0][DUR_W-1:0]     dur,
   output logic [CHANNELS-1:0]                busy,
   output logic [CHANNELS-1:0]                done,
   output logic                               tick,
   output logic                               wave,
   output logic [idx_w(CHANNELS)-1:0]         active_ch
);

   localparam int AW = idx_w(CHANNELS);

   logic [CHANNELS-1:0] ch_tick;
   logic [CHANNELS-1:0] ch_phase;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      tone_channel #(
         .N     (N),
         .DUR_W (DUR_W)
      ) u_ch (
         .clk    (clk),
         .nRst   (nRst),
         .mode   (state),
         .start  (start[g]),
         .period (period[g]),
         .dur    (dur[g]),
         .busy   (busy[g]),
         .done   (done[g]),
         .tick   (ch_tick[g]),
         .phase  (ch_phase[g])
      );
   end

   // The final tick lands in the cycle busy drops, so a ticking channel stays selectable.
   always_comb begin
      tick      = 1'b0;
      wave      = 1'b0;
      active_ch = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (busy[i] || ch_tick[i]) begin
            active_ch = AW'(i);
            tick      = ch_tick[i];
            wave      = ch_phase[i];
         end
      end
   end

endmodule

// File: tb/tb_tone_gen.sv
// Randomized + directed bench for tone_gen with a note-timeline reference model and scoreboard.
module tb_tone_gen;
   import snd_pkg::*;

   localparam int CH = 2;

   logic                 clk;
   logic                 nRst;
   MODE_TYPES            mode;
   logic [CH-1:0]        start;
   logic [CH-1:0][7:0]   period;
   logic [CH-1:0][7:0]   dur;
   logic [CH-1:0]        busy;
   logic [CH-1:0]        done;
   logic                 tick;
   logic                 wave;
   logic [0:0]           active_ch;

   tone_gen #(.N(8), .DUR_W(8), .CHANNELS(CH)) dut (
      .clk       (clk),
      .nRst      (nRst),
      .state     (mode),
      .start     (start),
      .period    (period),
      .dur       (dur),
      .busy      (busy),
      .done      (done),
      .tick      (tick),
      .wave      (wave),
      .active_ch (active_ch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [CH-1:0] busy;
      logic [CH-1:0] done;
      logic          tick;
      logic          wave;
      logic          act;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference: each playing note is a start cycle plus (P, D); everything else is arithmetic on elapsed cycles.
   bit act_m[CH];
   int k0_m[CH];
   int p_m[CH];
   int d_m[CH];
   int cyc = 0;

   task automatic chk(input string name, input int actual, input int expected);
      n_chk++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
      end
   endtask

   always @(negedge nRst) begin
      for (int i = 0; i < CH; i++) act_m[i] = 1'b0;
   end

   always @(posedge clk) begin
      exp_t x;
      int   sel;
      if (!nRst) begin
         for (int i = 0; i < CH; i++) act_m[i] = 1'b0;
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (mode == OFF) act_m[i] = 1'b0;
            else if (start[i]) begin
               if (dur[i] != 0) begin
                  act_m[i] = 1'b1;
                  k0_m[i]  = cyc;
                  p_m[i]   = int'(period[i]);
                  d_m[i]   = int'(dur[i]);
               end else act_m[i] = 1'b0;
            end
         end
      end
      cyc++;
      x.busy = '0; x.done = '0; x.tick = 1'b0; x.wave = 1'b0; x.act = 1'b0;
      sel = -1;
      for (int i = CH - 1; i >= 0; i--) begin
         bit b, t, w;
         b = 0; t = 0; w = 0;
         if (act_m[i]) begin
            int e, l, fin, n;
            e   = cyc - k0_m[i];
            l   = p_m[i] + 1;
            fin = d_m[i] * l + 1;
            b   = (e >= 1) && (e < fin);
            t   = (e >= l + 1) && (e <= fin) && ((e - 1) % l == 0);
            x.done[i] = (e == fin);
            n = (e >= 1) ? (e - 1) / l : 0;
            if (n > d_m[i]) n = d_m[i];
            w = n[0];
         end
         x.busy[i] = b;
         if (b || t) begin
            sel    = i;
            x.tick = t;
            x.wave = w;
         end
      end
      if (sel >= 0) x.act = sel[0];
      exp_q.push_back(x);
   end

   always @(negedge clk) begin
      exp_t x;
      if (exp_q.size() > 0) x = exp_q.pop_front();
      if (!nRst) begin
         x.busy = '0; x.done = '0; x.tick = 1'b0; x.wave = 1'b0; x.act = 1'b0;
      end
      chk("busy", int'(busy), int'(x.busy));
      chk("done", int'(done), int'(x.done));
      chk("tick", int'(tick), int'(x.tick));
      chk("wave", int'(wave), int'(x.wave));
      chk("active_ch", int'(active_ch), int'(x.act));
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [CH-1:0] s, input logic [7:0] p0, input logic [7:0] d0,
                     input logic [7:0] p1, input logic [7:0] d1);
      period[0] = p0; dur[0] = d0;
      period[1] = p1; dur[1] = d1;
      start = s;
      step(1);
      start = '0;
   endtask

   initial begin
      nRst = 1'b0; mode = ON; start = '0; period = '0; dur = '0;
      step(3);
      nRst = 1'b1;
      step(3);

      // Basic note and edge values
      go(2'b01, 8'd3, 8'd2, 8'd0, 8'd0);   step(12);
      go(2'b01, 8'd0, 8'd3, 8'd0, 8'd0);   step(6);
      go(2'b01, 8'd5, 8'd0, 8'd0, 8'd0);   step(4);

      // Priority: ch1 long note, ch0 pre-empts then releases
      go(2'b10, 8'd0, 8'd0, 8'd1, 8'd10);  step(4);
      go(2'b01, 8'd4, 8'd1, 8'd1, 8'd10);  step(20);

      // Restart mid-note, then start on the final tick
      go(2'b01, 8'd5, 8'd4, 8'd0, 8'd0);   step(4);
      go(2'b01, 8'd2, 8'd2, 8'd0, 8'd0);   step(12);
      go(2'b01, 8'd1, 8'd2, 8'd0, 8'd0);   step(4);
      go(2'b01, 8'd3, 8'd1, 8'd0, 8'd0);   step(8);

      // Global disable with a start attempt while off
      go(2'b11, 8'd2, 8'd9, 8'd3, 8'd9);   step(5);
      mode = OFF;
      go(2'b11, 8'd1, 8'd3, 8'd1, 8'd3);   step(2);
      mode = ON;                           step(5);

      // Asynchronous reset mid-note
      go(2'b11, 8'd2, 8'd20, 8'd1, 8'd20); step(4);
      nRst = 1'b0;
      #1;
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_done", int'(done), 0);
      chk("async_rst_tick", int'(tick), 0);
      chk("async_rst_wave", int'(wave), 0);
      chk("async_rst_active_ch", int'(active_ch), 0);
      step(3);
      nRst = 1'b1;
      step(6);

      // Random traffic
      for (int it = 0; it < 1500; it++) begin
         mode = ($urandom_range(0, 99) < 5) ? OFF : ON;
         for (int i = 0; i < CH; i++) begin
            start[i]  = ($urandom_range(0, 11) == 0);
            period[i] = 8'($urandom_range(0, 6));
            dur[i]    = 8'($urandom_range(0, 4));
         end
         step(1);
      end
      mode = ON; start = '0;
      step(40);

      // Maximum period and duration on ch1
      go(2'b10, 8'd0, 8'd0, 8'd255, 8'd255);
      step(255 * 256 + 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tone_gen.md
# tone_gen

Multi-channel square-wave tone generator for the game's sound path. Each channel plays a note of programmable half-period for a programmable number of half-periods, then retires with a done pulse. The lowest-index busy channel drives the speaker output. The block generalises the single-channel free-running oscillator with per-channel duration, start/restart handshakes, a square-wave output and fixed-priority channel selection.

## Interface
- `N`, 8: half-period counter width.
- `DUR_W`, 8: duration counter width, counted in ticks.
- `CHANNELS`, 2: number of independent tone channels; minimum 1.
- `clk` input, 1: system clock.
- `nRst` input, 1: asynchronous active-low reset.
- `state` input, `MODE_TYPES`: global sound enable, `OFF`/`ON`.
- `start` input, `[CHANNELS]`: per-channel one-cycle start request.
- `period` input, `[CHANNELS][N]`: half-period P; a tick occurs every P+1 cycles. Sampled at start.
- `dur` input, `[CHANNELS][DUR_W]`: note length D in ticks. Sampled at start.
- `busy` output, `[CHANNELS]`: channel is playing.
- `done` output, `[CHANNELS]`: one-cycle pulse on natural completion.
- `tick` output, 1: one-cycle pulse; the selected channel's half-period elapsed.
- `wave` output, 1: square wave of the selected channel.
- `active_ch` output, `$clog2(CHANNELS)` (min 1): index of the selected channel; 0 when none is busy.

## Operation
- Each channel has two states:
  - IDLE → PLAY when `start` is high, `state==ON` and D≠0. Latch P and D, clear count, clear ticks_left, clear phase.
  - PLAY → IDLE on the D-th tick, or on `state==OFF`.
- Start with D=0 is ignored. The channel stays or falls IDLE with no done pulse.
- Counting in PLAY:
  - While count < P, count increments.
  - When count ≥ P, count resets to 0, ch_tick is set for the next cycle and phase toggles with it.
  - P=0 gives a tick every cycle.
- Ticks are counted per channel. The D-th tick asserts `done` and drops `busy` in the same cycle.
- Restart: `start` while in PLAY reloads P and D and clears count, phase and tick count. No done pulse is emitted for the aborted note. A start coinciding with the final tick also restarts, and done is suppressed.
- `state==OFF` aborts all channels: IDLE, counters cleared, phase 0, no done. Starts are ignored while OFF.
- Selection: the lowest-index busy channel is selected.
  - `tick`, `wave` and `active_ch` follow the selected channel.
  - With no busy channel, `tick`=0, `wave`=0 and `active_ch`=0.
  - Selection is combinational from the registered busy/phase/tick values, so no extra latency is added.
- Width rules:
  - Count is N bits and never wraps, because it is compared against latched P ≤ 2^N−1.
  - ticks_left is DUR_W bits; D=2^DUR_W−1 must complete without overflow.

## Timing
- Reset: `busy`, `done`, `tick`, `wave`, `active_ch`, and all internal counters, phases and states are 0.
- Start sampled at cycle k:
  - `busy` is high from k+1, with count=0 at k+1.
  - The first tick is at k+P+2. Subsequent ticks follow every P+1 cycles.
- The final tick, the `done` pulse and `busy` falling all occur in the same cycle.
- Abort (`state` OFF, or restart) takes effect on the next edge. An in-flight tick that would have asserted is dropped.
- Reset asserted mid-note clears everything immediately; no done pulse is emitted.

## Structure
- Shared package `snd_pkg`: `MODE_TYPES` (`OFF`=0, `ON`=1) and the channel state enum `TONE_STATE` (IDLE, PLAY).
- Sub-module `tone_channel`: one channel's FSM, counters and phase. It is instantiated CHANNELS times via generate.
- Top level contains only the priority selector and output muxing.

## Test plan
- Reset: hold `nRst` low mid-activity → all outputs 0 asynchronously, and they stay 0 after release until a start.
- Basic note: ch0, P=3, D=2, start at cycle 0 → `busy` high cycles 1–8; `tick` at 5 and 9; `wave` 1 at 5–8 and 0 from 9; `done[0]` at 9.
- Edge values:
  - P=0, D=3 → ticks on three consecutive cycles.
  - D=0 → no busy and no done.
  - P=255, D=255 → 255 ticks spaced 256 cycles apart, then done.
- Priority: ch1 P=1 D=10, then ch0 P=4 D=1 started mid-note → output switches to ch0 (`active_ch`=0). After `done[0]`, output returns to ch1 with ch1's tick cadence unbroken.
- Restart and collision:
  - Restart ch0 mid-note with P=2 → no done, and the new first tick arrives 4 cycles after the start.
  - Start coinciding with the final tick → no done; `busy` stays high.
- Enable: `state`=OFF while both channels play → both go IDLE next cycle with no done and `wave` 0. A start while OFF is ignored.
